// File: rtl/serial_mouse_uart_rx_if.sv
// rtl/serial_mouse_uart_rx_if.sv - FIFO read side and error-flag bundle of the mouse UART receiver
interface serial_mouse_uart_rx_if #(
    parameter int FIFO_DEPTH = 16
);
    logic                          rd_en;
    logic [7:0]                    rd_data;
    logic                          rd_valid;
    logic [$clog2(FIFO_DEPTH):0]   fifo_count;
    logic                          framing_err;
    logic                          overrun;
    logic                          err_clr;

    // master: the register file / CPU side that pops characters and clears errors
    modport master (
        output rd_en, err_clr,
        input  rd_data, rd_valid, fifo_count, framing_err, overrun
    );

    // slave: the receiver itself
    modport slave (
        input  rd_en, err_clr,
        output rd_data, rd_valid, fifo_count, framing_err, overrun
    );
endinterface

// File: rtl/serial_mouse_uart_rx.sv
// rtl/serial_mouse_uart_rx.sv - 16x oversampling serial receiver with FWFT FIFO and sticky error flags
module serial_mouse_uart_rx #(
    parameter int CLKFREQ    = 50_000_000,
    parameter int BAUD       = 1200,
    parameter int DATA_BITS  = 7,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_in,
    input  logic                  rx_enable,
    serial_mouse_uart_rx_if.slave bus
);

    localparam int             DIV      = CLKFREQ / (BAUD * 16);
    localparam int             DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0]  DIV_M1   = DW'(DIV - 1);
    localparam int             AW       = $clog2(FIFO_DEPTH);
    localparam logic [2:0]     LAST_BIT = 3'(DATA_BITS - 1);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, rxs_q;
    logic [DW-1:0] div_cnt_q;
    logic [3:0]    tick_cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q;
    logic          push_q;
    logic [7:0]    push_data_q;
    logic          framing_q, overrun_q;
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          tick;
    logic          start_entry, data_entry, sample_data, stop_ok, stop_bad;
    logic [AW:0]   count;
    logic          pop, full, accept;

    assign tick   = (div_cnt_q == DIV_M1);
    assign count  = wr_ptr_q - rd_ptr_q;
    assign full   = (count == FULL_CNT);
    assign pop    = bus.rd_en && (count != '0);
    assign accept = push_q && (!full || pop);

    assign bus.rd_valid    = (count != '0);
    assign bus.rd_data     = (count != '0) ? mem_q[rd_ptr_q[AW-1:0]] : 8'h00;
    assign bus.fifo_count  = count;
    assign bus.framing_err = framing_q;
    assign bus.overrun     = overrun_q;

    // Two-flop synchroniser for the asynchronous line; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            rxs_q   <= 1'b1;
        end else begin
            sync1_q <= rx_in;
            rxs_q   <= sync1_q;
        end
    end

    // Receiver state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-cycle control strobes for the datapath
    always_comb begin
        state_d     = state_q;
        start_entry = 1'b0;
        data_entry  = 1'b0;
        sample_data = 1'b0;
        stop_ok     = 1'b0;
        stop_bad    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rxs_q && rx_enable) begin
                    state_d     = START;
                    start_entry = 1'b1;
                end
            end
            START: begin
                if (tick && tick_cnt_q == 4'd7) begin
                    if (rxs_q) begin
                        state_d = IDLE;
                    end else begin
                        state_d    = DATA;
                        data_entry = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    sample_data = 1'b1;
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick && tick_cnt_q == 4'd15) begin
                    if (rxs_q) begin
                        stop_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxs_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Baud tick divider and tick phase; both restart at the detected start edge
    always_ff @(posedge clk) begin
        if (reset || start_entry) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
            if (data_entry) begin
                tick_cnt_q <= '0;
            end else if (tick) begin
                tick_cnt_q <= tick_cnt_q + 4'd1;
            end
        end
    end

    // Shift register assembles bits LSB first; unused top bit stays 0 for 7-bit characters
    always_ff @(posedge clk) begin
        if (reset || start_entry) begin
            shift_q   <= '0;
            bit_idx_q <= '0;
        end else if (sample_data) begin
            shift_q[bit_idx_q] <= rxs_q;
            bit_idx_q          <= bit_idx_q + 3'd1;
        end
    end

    // A good stop bit schedules the push for the next clock
    always_ff @(posedge clk) begin
        if (reset) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q <= stop_ok;
            if (stop_ok) begin
                push_data_q <= shift_q;
            end
        end
    end

    // FIFO pointers; the extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    // FIFO storage; contents are only meaningful below the write pointer
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_q;
        end
    end

    // Sticky error flags; a new error in the same cycle as a clear wins
    always_ff @(posedge clk) begin
        if (reset) begin
            framing_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (stop_bad) begin
                framing_q <= 1'b1;
            end else if (bus.err_clr) begin
                framing_q <= 1'b0;
            end
            if (push_q && !accept) begin
                overrun_q <= 1'b1;
            end else if (bus.err_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_mouse_uart_rx.sv
// tb/tb_serial_mouse_uart_rx.sv - scoreboard bench for the serial mouse UART receiver
module tb_serial_mouse_uart_rx;

    localparam int CLKFREQ    = 76_800;
    localparam int BAUD       = 1200;
    localparam int DATA_BITS  = 7;
    localparam int FIFO_DEPTH = 16;
    localparam int DIV        = 4;
    localparam int BIT        = 16 * DIV;
    localparam int STOP_EDGE  = 3 + (8 + 16 * (DATA_BITS + 1)) * DIV;

    logic clk = 1'b0;
    logic reset;
    logic rx_in;
    logic rx_enable;

    serial_mouse_uart_rx_if #(.FIFO_DEPTH(FIFO_DEPTH)) bus ();

    serial_mouse_uart_rx #(
        .CLKFREQ   (CLKFREQ),
        .BAUD      (BAUD),
        .DATA_BITS (DATA_BITS),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx_in    (rx_in),
        .rx_enable(rx_enable),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] exp_q[$];
    logic       model_ovr;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] val, input logic stop_v);
        rx_in = 1'b0;
        idle(BIT);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx_in = val[i];
            idle(BIT);
        end
        rx_in = stop_v;
        idle(BIT);
    endtask

    task automatic expect_char(input logic [7:0] val);
        if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(val);
        else model_ovr = 1'b1;
    endtask

    task automatic pop_one(output logic [7:0] d, output logic v);
        d = bus.rd_data;
        v = bus.rd_valid;
        bus.rd_en = 1'b1;
        idle(1);
        bus.rd_en = 1'b0;
    endtask

    task automatic clear_errors;
        bus.err_clr = 1'b1;
        idle(1);
        bus.err_clr = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle(4);
        reset = 1'b0;
        exp_q.delete();
        model_ovr = 1'b0;
        idle(2);
        checks++; if (bus.rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h want 00", bus.rd_data); end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
        checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", bus.fifo_count); end
        checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL reset_framing: got %b want 0", bus.framing_err); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", bus.overrun); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic       v;
        fork
            begin
                send_frame(8'h4D, 1'b1);
            end
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1;
                checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", bus.rd_valid); end
                repeat (2) @(posedge clk);
                #1;
                checks++; if (bus.rd_valid !== 1'b1) begin errors++; $display("FAIL single_latency_valid: got %b want 1", bus.rd_valid); end
            end
        join
        expect_char(8'h4D);
        checks++; if (bus.fifo_count !== 5'(exp_q.size())) begin errors++; $display("FAIL single_count: got %0d want %0d", bus.fifo_count, exp_q.size()); end
        pop_one(d, v);
        checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL single_data: got %h/%b want %h/1", d, v, exp_q[0]); end
        void'(exp_q.pop_front());
        checks++; if (bus.rd_valid !== 1'b0 || bus.fifo_count !== 5'd0) begin
            errors++; $display("FAIL single_after_pop: got valid=%b count=%0d want 0/0", bus.rd_valid, bus.fifo_count);
        end
    endtask

    task automatic test_false_start;
        logic [7:0] d;
        logic       v;
        rx_in = 1'b0;
        idle(8 * DIV - 17);
        rx_in = 1'b1;
        idle(3 * BIT);
        checks++; if (bus.fifo_count !== 5'd0 || bus.framing_err !== 1'b0) begin
            errors++; $display("FAIL false_start: got count=%0d ferr=%b want 0/0", bus.fifo_count, bus.framing_err);
        end
        send_frame(8'h40, 1'b1);
        expect_char(8'h40);
        idle(4);
        pop_one(d, v);
        checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL false_start_next: got %h/%b want %h/1", d, v, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_rx_disable;
        rx_enable = 1'b0;
        send_frame(8'h11, 1'b1);
        idle(BIT);
        checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL rx_disable: got count=%0d want 0", bus.fifo_count); end
        rx_enable = 1'b1;
    endtask

    task automatic test_framing;
        logic [7:0] d;
        logic       v;
        send_frame(8'h33, 1'b0);
        checks++; if (bus.framing_err !== 1'b1) begin errors++; $display("FAIL framing_set: got %b want 1", bus.framing_err); end
        checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL framing_count: got %0d want 0", bus.fifo_count); end
        clear_errors();
        checks++; if (bus.framing_err !== 1'b0) begin errors++; $display("FAIL framing_clr: got %b want 0", bus.framing_err); end
        idle(2 * BIT);
        rx_in = 1'b1;
        idle(2 * BIT);
        checks++; if (bus.framing_err !== 1'b0 || bus.fifo_count !== 5'd0) begin
            errors++; $display("FAIL framing_single_event: got ferr=%b count=%0d want 0/0", bus.framing_err, bus.fifo_count);
        end
        send_frame(8'h08, 1'b1);
        expect_char(8'h08);
        idle(4);
        pop_one(d, v);
        checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL framing_next: got %h/%b want %h/1", d, v, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    task automatic test_overrun;
        logic [7:0] d;
        logic       v;
        for (int i = 0; i <= 16; i++) begin
            send_frame(8'(i), 1'b1);
            expect_char(8'(i));
        end
        idle(4);
        checks++; if (bus.fifo_count !== 5'(exp_q.size())) begin errors++; $display("FAIL ovr_count: got %0d want %0d", bus.fifo_count, exp_q.size()); end
        checks++; if (bus.overrun !== model_ovr) begin errors++; $display("FAIL ovr_flag: got %b want %b", bus.overrun, model_ovr); end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pop_one(d, v);
            checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL ovr_read%0d: got %h/%b want %h/1", i, d, v, exp_q[0]); end
            void'(exp_q.pop_front());
        end
        checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL ovr_empty: got %b want 0", bus.rd_valid); end
        pop_one(d, v);
        checks++; if (bus.fifo_count !== 5'd0) begin errors++; $display("FAIL pop_empty_ignored: got %0d want 0", bus.fifo_count); end
        clear_errors();
        model_ovr = 1'b0;
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr: got %b want 0", bus.overrun); end
    endtask

    task automatic test_pop_at_full;
        logic [7:0] d;
        logic [7:0] head;
        logic       v;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            send_frame(8'h60 + 8'(i), 1'b1);
            expect_char(8'h60 + 8'(i));
        end
        idle(4);
        checks++; if (bus.fifo_count !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", bus.fifo_count); end
        fork
            begin
                send_frame(8'h55, 1'b1);
            end
            begin
                repeat (STOP_EDGE) @(posedge clk);
                #1;
                head = bus.rd_data;
                bus.rd_en = 1'b1;
                @(posedge clk);
                #1;
                bus.rd_en = 1'b0;
            end
        join
        checks++; if (head !== exp_q[0]) begin errors++; $display("FAIL simul_head: got %h want %h", head, exp_q[0]); end
        void'(exp_q.pop_front());
        exp_q.push_back(8'h55);
        idle(4);
        checks++; if (bus.fifo_count !== 5'd16) begin errors++; $display("FAIL simul_count: got %0d want 16", bus.fifo_count); end
        checks++; if (bus.overrun !== 1'b0) begin errors++; $display("FAIL simul_overrun: got %b want 0", bus.overrun); end
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            pop_one(d, v);
            checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL simul_read%0d: got %h/%b want %h/1", i, d, v, exp_q[0]); end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        logic       v;
        fork
            begin
                send_frame(8'h7F, 1'b1);
            end
            begin
                repeat (4 * BIT + 24) @(posedge clk);
                #1;
                reset = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
        join
        idle(BIT);
        checks++; if (bus.fifo_count !== 5'd0 || bus.rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_mid_frame: got count=%0d valid=%b want 0/0", bus.fifo_count, bus.rd_valid);
        end
        send_frame(8'h2A, 1'b1);
        expect_char(8'h2A);
        idle(4);
        checks++; if (bus.fifo_count !== 5'(exp_q.size())) begin errors++; $display("FAIL after_reset_count: got %0d want %0d", bus.fifo_count, exp_q.size()); end
        pop_one(d, v);
        checks++; if (!v || d !== exp_q[0]) begin errors++; $display("FAIL after_reset_data: got %h/%b want %h/1", d, v, exp_q[0]); end
        void'(exp_q.pop_front());
    endtask

    initial begin
        reset       = 1'b1;
        rx_in       = 1'b1;
        rx_enable   = 1'b1;
        bus.rd_en   = 1'b0;
        bus.err_clr = 1'b0;
        model_ovr   = 1'b0;
        test_reset();
        test_single();
        test_false_start();
        test_rx_disable();
        test_framing();
        test_overrun();
        test_pop_at_full();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_mouse_uart_rx.md
Name: serial_mouse_uart_rx

Overview:
- Receive side of the PC's COM-port model; sits directly downstream of the PS/2-to-Microsoft-serial-mouse converter.
- Oversamples the converter's idle-high serial line `rd` (1200 baud, LSB-first, 1 start, 1 stop).
- Assembles 7- or 8-bit characters and queues them in a first-word-fall-through FIFO for the UART register file / CPU bus.
- Reports framing and overrun errors as sticky flags.

Parameters:
- CLKFREQ, 50_000_000: system clock frequency in Hz.
- BAUD, 1200: line rate.
- DATA_BITS, 7: data bits per character, 7 or 8; the mouse protocol uses 7.
- FIFO_DEPTH, 16: FIFO entries; must be a power of two, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx_in  in  1  serial line, idle high; asynchronous to clk.
- rx_enable  in  1  when 0, no new start bit is accepted; a frame already in progress completes.
- rd_en  in  1  pop request; consumes the head entry.
- rd_data  out  8  FIFO head; upper unused bits are 0 for DATA_BITS=7.
- rd_valid  out  1  FIFO not empty.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of stored entries.
- framing_err  out  1  sticky; a stop bit was sampled low.
- overrun  out  1  sticky; a character was dropped because the FIFO was full.
- err_clr  in  1  clears framing_err and overrun.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: rd_data=0, rd_valid=0, fifo_count=0, framing_err=0, overrun=0; receiver state IDLE; FIFO pointers 0.
- Reset mid-frame aborts the partial character with no push.
- Synchroniser: rx_in passes through a 2-flop synchroniser, initialised to 1. All decisions use the synchronised value rxs.
- Tick generator: DIV = CLKFREQ/(BAUD*16), integer floor, 2604 at the defaults.
  - Counter reloads on reaching DIV-1, issuing a 1-clk tick.
  - Counter and tick-phase count are cleared on entry to START, so sampling is aligned to the detected edge.
- Receiver FSM (states IDLE, START, DATA, STOP, BREAK):
  - IDLE: when rxs==0 and rx_enable==1, go to START.
  - START: after 8 ticks (mid start bit), resample rxs.
    - rxs==1: false start; return to IDLE with no error.
    - rxs==0: go to DATA.
  - DATA: every 16 ticks, sample rxs into shift register bit n, LSB first, n=0..DATA_BITS-1. After the last bit, go to STOP.
  - STOP: 16 ticks later, sample rxs.
    - rxs==1: push the character (zero-extended to 8 bits); go to IDLE.
    - rxs==0: set framing_err, discard the character, go to BREAK.
  - BREAK: wait for rxs==1, then go to IDLE. A held-low line yields exactly one framing error.
- Latency: push occurs 1 clk after the stop-bit sample; rd_valid rises on the following clk edge.
- FIFO:
  - rd_data always shows the head entry; it is undefined-but-stable when empty and reads 0 after reset.
  - Pop happens on a clk edge with rd_en=1 and rd_valid=1; rd_en with the FIFO empty is ignored.
  - A push is accepted if fifo_count<FIFO_DEPTH, or if a pop occurs in the same cycle. A simultaneous push and pop with the FIFO full is accepted and fifo_count is unchanged.
  - A simultaneous push and pop with the FIFO empty is impossible, since no pop occurs when empty.
  - A rejected push sets overrun; stored data is untouched.
  - Pointers wrap modulo FIFO_DEPTH; count = wr-rd using an extra MSB.
- Flags: err_clr clears both sticky flags. If an error event occurs in the same cycle as err_clr, the flag is set (set wins).
- rx_enable going low mid-frame does not abort the frame.
- The receiver ignores the 8th bit of a 10-bit-framed 8N1-style mouse word when DATA_BITS=7. That bit is 1 and is seen as the stop bit, which is the intended mouse-compatible behaviour.

Test Plan:
- Single character: after reset, drive 7N1 frame 0x4D ('M') at 41664 clk/bit → after the stop sample, rd_valid=1, rd_data=0x4D, fifo_count=1; rd_en for 1 clk → rd_valid=0, count=0.
- False start: rx_in low for 20000 clk (<half bit), then high → FSM returns to IDLE, no push, framing_err=0. A following valid 0x40 is received correctly.
- Framing error: frame 0x33 with stop bit forced 0, line held low for 3 bit times → framing_err=1, fifo_count=0, only one error event. err_clr → 0, and the next 0x08 is received.
- Overrun and full wrap: 17 back-to-back frames 0x00..0x10, no reads → count=16, overrun=1. Reads return 0x00..0x0F in order; 0x10 is lost.
- Simultaneous push/pop at full: with 16 entries, assert rd_en on the push cycle of 0x55 → count stays 16, overrun=0. The 16th read returns 0x55.
- Reset mid-frame: assert reset for 1 clk during data bit 3 of 0x7F → no push, count=0. The next frame 0x2A is received correctly.
